countdown_sequencer: RTL and testbench

- Sequences the pre-round "3, 2, 1, FIGHT" overlay and owns the countdown sprite ROM address path.
- Counts video frames to step through the digit sprites and computes the 64x64 sprite ROM address for a 2x-scaled on-screen window.
- Tells the palette/mux stage which sprite to show and when the overlay is visible.
- Releases player controls when FIGHT begins; sits between the game FSM and the countdown sprite ROMs/palettes.

---
 rtl/countdown_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_countdown_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_sequencer.sv
// -----------------------------------------------------------------------------
// countdown_sequencer
//
// Sequences the pre-round "3, 2, 1, FIGHT" overlay and generates the sprite
// ROM address for a 64x64 sprite drawn 2x-scaled into a 128x128 screen window.
// Video frames are counted from the pixel (0,0) position. Each digit is shown
// for FRAMES_PER_STEP frames and FIGHT for FIGHT_FRAMES frames. Player controls
// are released when FIGHT begins.
//
// Build option:
//   COUNTDOWN_PAUSE_EN  when defined, pause=1 freezes the countdown (frame ticks
//                       are ignored) while the overlay keeps drawing. When
//                       undefined, the pause port is present but has no effect.
//
// Ports:
//   vga_clk      in   1   pixel clock, all state updates on posedge
//   reset_n      in   1   asynchronous active-low reset
//   DrawX        in  10   current pixel column
//   DrawY        in  10   current pixel row
//   start        in   1   one-cycle request to begin the countdown
//   abort        in   1   level, forces IDLE
//   pause        in   1   level, freezes the countdown (pause build only)
//   sprite_sel   out  2   0=digit 3, 1=digit 2, 2=digit 1, 3=FIGHT
//   sprite_on    out  1   registered: pixel inside window while busy
//   rom_address  out 12   registered 64x64 sprite ROM address
//   fight_pulse  out  1   one-cycle pulse on the first FIGHT cycle
//   controls_en  out  1   high in FIGHT and DONE
//   busy         out  1   high in CD3, CD2, CD1 and FIGHT
// -----------------------------------------------------------------------------
module countdown_sequencer #(
  parameter int FRAMES_PER_STEP = 60,
  parameter int FIGHT_FRAMES    = 30,
  parameter int SPR_X           = 256,
  parameter int SPR_Y           = 176
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        start,
  input  logic        abort,
  input  logic        pause,
  output logic [1:0]  sprite_sel,
  output logic        sprite_on,
  output logic [11:0] rom_address,
  output logic        fight_pulse,
  output logic        controls_en,
  output logic        busy
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int MAX_FRAMES = (FRAMES_PER_STEP > FIGHT_FRAMES) ?
                              FRAMES_PER_STEP : FIGHT_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [CNT_W-1:0] FIGHT_LAST = CNT_W'(FIGHT_FRAMES - 1);

  // Window bounds are compared at 11 bits so SPR_X+128 cannot wrap.
  localparam logic [10:0] WIN_X_LO = 11'(SPR_X);
  localparam logic [10:0] WIN_X_HI = 11'(SPR_X + 128);
  localparam logic [10:0] WIN_Y_LO = 11'(SPR_Y);
  localparam logic [10:0] WIN_Y_HI = 11'(SPR_Y + 128);

  localparam logic [9:0]  ORG_X    = 10'(SPR_X);
  localparam logic [9:0]  ORG_Y    = 10'(SPR_Y);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CD3   = 3'd1,
    S_CD2   = 3'd2,
    S_CD1   = 3'd3,
    S_FIGHT = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               frame_tick_q;
  logic               fight_pulse_q, fight_pulse_d;
  logic               sprite_on_q, sprite_on_d;
  logic [11:0]        rom_address_q, rom_address_d;

  logic               tick_en;
  logic               win;
  logic [9:0]         dx, dy;
  logic [9:0]         half_x, half_y;

  // ---------------------------------------------------------------------------
  // Frame tick: one cycle, the cycle after pixel (0,0) is presented
  // ---------------------------------------------------------------------------
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= (DrawX == 10'd0) && (DrawY == 10'd0);
    end
  end

`ifdef COUNTDOWN_PAUSE_EN
  // Pause only masks the tick, so start/abort still act immediately.
  assign tick_en = frame_tick_q && !pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign tick_en      = frame_tick_q;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer: next state and frame counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    fight_pulse_d = 1'b0;

    if (abort) begin
      state_d     = S_IDLE;
      frame_cnt_d = '0;
    end else if (start && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
      // A tick arriving together with start is swallowed here.
      state_d     = S_CD3;
      frame_cnt_d = '0;
    end else if (tick_en) begin
      unique case (state_q)
        S_CD3: begin
          if (frame_cnt_q == STEP_LAST) begin
            state_d     = S_CD2;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
        S_CD2: begin
          if (frame_cnt_q == STEP_LAST) begin
            state_d     = S_CD1;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
        S_CD1: begin
          if (frame_cnt_q == STEP_LAST) begin
            state_d     = S_FIGHT;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
        S_FIGHT: begin
          if (frame_cnt_q == FIGHT_LAST) begin
            state_d     = S_DONE;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
        default: begin
          // IDLE and DONE do not count frames.
        end
      endcase
    end

    fight_pulse_d = (state_q == S_CD1) && (state_d == S_FIGHT);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      frame_cnt_q   <= '0;
      fight_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      fight_pulse_q <= fight_pulse_d;
    end
  end

  // ---------------------------------------------------------------------------
  // State decode
  // ---------------------------------------------------------------------------
  always_comb begin
    sprite_sel  = 2'd0;
    busy        = 1'b0;
    controls_en = 1'b0;
    unique case (state_q)
      S_CD3: begin
        sprite_sel = 2'd0;
        busy       = 1'b1;
      end
      S_CD2: begin
        sprite_sel = 2'd1;
        busy       = 1'b1;
      end
      S_CD1: begin
        sprite_sel = 2'd2;
        busy       = 1'b1;
      end
      S_FIGHT: begin
        sprite_sel  = 2'd3;
        busy        = 1'b1;
        controls_en = 1'b1;
      end
      S_DONE: begin
        controls_en = 1'b1;
      end
      default: begin
        // IDLE: everything low.
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pixel path: window test and 2x-scaled ROM address, one cycle of latency
  // ---------------------------------------------------------------------------
  always_comb begin
    win = ({1'b0, DrawX} >= WIN_X_LO) && ({1'b0, DrawX} < WIN_X_HI) &&
          ({1'b0, DrawY} >= WIN_Y_LO) && ({1'b0, DrawY} < WIN_Y_HI);

    // 10-bit offsets; only meaningful (and < 128) inside the window.
    dx     = DrawX - ORG_X;
    dy     = DrawY - ORG_Y;
    half_x = dx >> 1;
    half_y = dy >> 1;

    sprite_on_d   = win && busy;
    rom_address_d = win ? (12'(half_x) + (12'(half_y) << 6)) : 12'd0;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sprite_on_q   <= 1'b0;
      rom_address_q <= 12'd0;
    end else begin
      sprite_on_q   <= sprite_on_d;
      rom_address_q <= rom_address_d;
    end
  end

  assign sprite_on   = sprite_on_q;
  assign rom_address = rom_address_q;
  assign fight_pulse = fight_pulse_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// -----------------------------------------------------------------------------
// Directed testbench for countdown_sequencer with FRAMES_PER_STEP=2,
// FIGHT_FRAMES=1. Frames are produced by presenting pixel (0,0) for one cycle,
// so a frame lasts only a couple of clocks.
// -----------------------------------------------------------------------------
module tb_countdown_sequencer;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        start, abort, pause;
  logic [1:0]  sprite_sel;
  logic        sprite_on;
  logic [11:0] rom_address;
  logic        fight_pulse, controls_en, busy;

  int tests  = 0;
  int failed = 0;

  countdown_sequencer #(
    .FRAMES_PER_STEP(2),
    .FIGHT_FRAMES   (1),
    .SPR_X          (256),
    .SPR_Y          (176)
  ) dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .start      (start),
    .abort      (abort),
    .pause      (pause),
    .sprite_sel (sprite_sel),
    .sprite_on  (sprite_on),
    .rom_address(rom_address),
    .fight_pulse(fight_pulse),
    .controls_en(controls_en),
    .busy       (busy)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  // Present pixel (0,0) for one cycle; the sequencer acts on the tick at the
  // second edge, so the new state is visible when this task returns.
  task automatic tick();
    DrawX = 10'd0;
    DrawY = 10'd0;
    step();
    DrawX = 10'd10;
    DrawY = 10'd10;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sel"},  32'(sprite_sel),  32'd0);
    check({tag, "_on"},   32'(sprite_on),   32'd0);
    check({tag, "_addr"}, 32'(rom_address), 32'd0);
    check({tag, "_fp"},   32'(fight_pulse), 32'd0);
    check({tag, "_ctl"},  32'(controls_en), 32'd0);
    check({tag, "_busy"}, 32'(busy),        32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    pause   = 1'b0;
    DrawX   = 10'd300;
    DrawY   = 10'd200;

    // Reset state, pixel mid-frame inside the window
    repeat (3) step();
    check_all_zero("rst");
    reset_n = 1'b1;
    repeat (3) tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_sel",  32'(sprite_sel), 32'd0);
    check("idle_ctl",  32'(controls_en), 32'd0);

    // Full sequence
    start = 1'b1;
    step();
    start = 1'b0;
    check("cd3_sel",  32'(sprite_sel), 32'd0);
    check("cd3_busy", 32'(busy), 32'd1);
    check("cd3_ctl",  32'(controls_en), 32'd0);
    tick();
    check("cd3b_sel", 32'(sprite_sel), 32'd0);
    check("cd3b_busy", 32'(busy), 32'd1);
    tick();
    check("cd2_sel",  32'(sprite_sel), 32'd1);
    tick();
    check("cd2b_sel", 32'(sprite_sel), 32'd1);
    tick();
    check("cd1_sel",  32'(sprite_sel), 32'd2);
    check("cd1_fp",   32'(fight_pulse), 32'd0);
    tick();
    check("cd1b_sel", 32'(sprite_sel), 32'd2);
    tick();
    check("fight_sel",  32'(sprite_sel), 32'd3);
    check("fight_fp",   32'(fight_pulse), 32'd1);
    check("fight_ctl",  32'(controls_en), 32'd1);
    check("fight_busy", 32'(busy), 32'd1);
    step();
    check("fight_fp_end", 32'(fight_pulse), 32'd0);
    check("fight_sel2",   32'(sprite_sel), 32'd3);
    tick();
    check("done_busy", 32'(busy), 32'd0);
    check("done_ctl",  32'(controls_en), 32'd1);
    check("done_sel",  32'(sprite_sel), 32'd0);
    repeat (2) tick();
    check("done_hold", 32'(controls_en), 32'd1);

    // Restart from DONE, then address path in CD3
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_ctl",  32'(controls_en), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    DrawX = 10'd256; DrawY = 10'd176;
    step();
    check("addr_tl",    32'(rom_address), 32'd0);
    check("addr_tl_on", 32'(sprite_on), 32'd1);
    DrawX = 10'd383; DrawY = 10'd303;
    step();
    check("addr_br",    32'(rom_address), 32'd4095);
    check("addr_br_on", 32'(sprite_on), 32'd1);
    DrawX = 10'd300; DrawY = 10'd200;
    step();
    check("addr_mid",    32'(rom_address), 32'd790);
    check("addr_mid_on", 32'(sprite_on), 32'd1);
    DrawX = 10'd384; DrawY = 10'd200;
    step();
    check("addr_xout",    32'(rom_address), 32'd0);
    check("addr_xout_on", 32'(sprite_on), 32'd0);
    DrawX = 10'd256; DrawY = 10'd175;
    step();
    check("addr_yout",    32'(rom_address), 32'd0);
    check("addr_yout_on", 32'(sprite_on), 32'd0);

    // Abort in CD2
    repeat (2) tick();
    check("pre_abort_sel", 32'(sprite_sel), 32'd1);
    DrawX = 10'd300; DrawY = 10'd200;
    step();
    check("pre_abort_on", 32'(sprite_on), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sel",  32'(sprite_sel), 32'd0);
    step();
    check("abort_on",   32'(sprite_on), 32'd0);
    check("abort_addr", 32'(rom_address), 32'd790);

    // Start during CD1 is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) tick();
    check("cd1_again_sel", 32'(sprite_sel), 32'd2);
    start = 1'b1;
    step();
    start = 1'b0;
    check("cd1_start_sel", 32'(sprite_sel), 32'd2);
    tick();
    check("cd1_start_sel2", 32'(sprite_sel), 32'd2);
    tick();
    check("cd1_start_fight", 32'(sprite_sel), 32'd3);
    tick();
    check("cd1_start_done", 32'(controls_en), 32'd1);
    check("cd1_start_done_busy", 32'(busy), 32'd0);

    // Start coincident with a frame tick: that tick is not counted
    DrawX = 10'd0; DrawY = 10'd0;
    step();
    start = 1'b1;
    DrawX = 10'd10; DrawY = 10'd10;
    step();
    start = 1'b0;
    check("sim_sel",  32'(sprite_sel), 32'd0);
    check("sim_busy", 32'(busy), 32'd1);
    tick();
    check("sim_tick1", 32'(sprite_sel), 32'd0);
    tick();
    check("sim_tick2", 32'(sprite_sel), 32'd1);

    // Abort and start together
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check("abst_busy", 32'(busy), 32'd0);
    check("abst_sel",  32'(sprite_sel), 32'd0);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check("abst_idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-sequence
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) tick();
    DrawX = 10'd300; DrawY = 10'd200;
    step();
    check("pre_rst_on",   32'(sprite_on), 32'd1);
    check("pre_rst_addr", 32'(rom_address), 32'd790);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    reset_n = 1'b1;
    step();
    repeat (3) tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_sel",  32'(sprite_sel), 32'd0);

`ifdef COUNTDOWN_PAUSE_EN
    // Pause in CD2 with one frame already counted
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) tick();
    check("pz_pre_sel", 32'(sprite_sel), 32'd1);
    pause = 1'b1;
    repeat (5) tick();
    check("pz_sel", 32'(sprite_sel), 32'd1);
    DrawX = 10'd300; DrawY = 10'd200;
    step();
    check("pz_on",   32'(sprite_on), 32'd1);
    check("pz_addr", 32'(rom_address), 32'd790);
    pause = 1'b0;
    tick();
    check("pz_resume_sel", 32'(sprite_sel), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
